// File: rtl/welcomer_sequencer_if.sv
// Bundle of the channel configuration inputs and status outputs of the
// welcomer sequencer. The master side supplies enables/durations and
// observes the status; the slave side is the sequencer itself.
interface welcomer_sequencer_if #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int COUNT_W = 16
);
  logic [NUM_CH-1:0]       in_channel_enable;
  logic [NUM_CH*CNT_W-1:0] in_durations;
  logic [NUM_CH-1:0]       out_channels;
  logic                    out_busy;
  logic [1:0]              out_state;
  logic                    out_presence;
  logic [COUNT_W-1:0]      out_welcome_count;

  modport master (
    output in_channel_enable, in_durations,
    input  out_channels, out_busy, out_state, out_presence, out_welcome_count
  );

  modport slave (
    input  in_channel_enable, in_durations,
    output out_channels, out_busy, out_state, out_presence, out_welcome_count
  );
endinterface

// File: rtl/welcomer_sequencer.sv
// Welcomer sequencer: debounces a raw presence sensor, fires NUM_CH timed
// output channels once per visit, then waits for the visitor to leave and
// holds off re-triggering for a cooldown period. Counts completed welcomes
// with saturation. All outputs come straight from registers.
module welcomer_sequencer #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 32,
  parameter int DEBOUNCE_CYCLES = 10000000,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int COUNT_W         = 16
) (
  input  logic                 in_clock,
  input  logic                 in_reset,
  input  logic                 in_presence_signal,
  welcomer_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WELCOME    = 2'd1,
    ST_WAIT_LEAVE = 2'd2,
    ST_COOLDOWN   = 2'd3
  } state_t;

  // A debounce count of 0 behaves like 1: accept on the first mismatching cycle.
  localparam logic [CNT_W-1:0] DEB_LAST_C   = (DEBOUNCE_CYCLES > 0) ? CNT_W'(DEBOUNCE_CYCLES - 1)
                                                                    : {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] COOL_LOAD_C  = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ONE_C = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX_C = {COUNT_W{1'b1}};

  logic [1:0]         sync_r;
  logic               pres_s;
  logic               pres_f_r;
  logic [CNT_W-1:0]   deb_cnt_r;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   ch_cnt_r     [NUM_CH];
  logic [CNT_W-1:0]   ch_cnt_nxt_s [NUM_CH];
  logic [NUM_CH-1:0]  ch_out_r;
  logic [NUM_CH-1:0]  ch_out_nxt_s;
  logic [CNT_W-1:0]   cool_cnt_r;
  logic [CNT_W-1:0]   cool_cnt_nxt_s;
  logic [COUNT_W-1:0] wcount_r;
  logic [COUNT_W-1:0] wcount_nxt_s;
  logic               busy_r;
  logic               all_done_s;

  assign pres_s = sync_r[1];

  // Synchronise the raw sensor and accept a new level only after it has been stable.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      sync_r    <= 2'b00;
      pres_f_r  <= 1'b0;
      deb_cnt_r <= CNT_ZERO_C;
    end else begin
      sync_r <= {sync_r[0], in_presence_signal};
      if (pres_s == pres_f_r) begin
        deb_cnt_r <= CNT_ZERO_C;
      end else if (deb_cnt_r >= DEB_LAST_C) begin
        pres_f_r  <= pres_s;
        deb_cnt_r <= CNT_ZERO_C;
      end else begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE_C;
      end
    end
  end

  // Next-state and next-counter logic of the welcome sequence.
  always_comb begin
    state_nxt_s    = state_r;
    ch_cnt_nxt_s   = ch_cnt_r;
    ch_out_nxt_s   = ch_out_r;
    cool_cnt_nxt_s = cool_cnt_r;
    wcount_nxt_s   = wcount_r;
    all_done_s     = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      all_done_s = all_done_s & (ch_cnt_r[i] == CNT_ZERO_C);
    end

    case (state_r)
      ST_IDLE: begin
        if (pres_f_r) begin
          state_nxt_s = ST_WELCOME;
          // Enables and durations are captured here; later changes are ignored.
          for (int i = 0; i < NUM_CH; i++) begin
            ch_cnt_nxt_s[i] = bus.in_channel_enable[i] ? bus.in_durations[i*CNT_W +: CNT_W]
                                                       : CNT_ZERO_C;
            ch_out_nxt_s[i] = bus.in_channel_enable[i] &&
                              (bus.in_durations[i*CNT_W +: CNT_W] != CNT_ZERO_C);
          end
        end else begin
          state_nxt_s  = ST_IDLE;
          ch_out_nxt_s = {NUM_CH{1'b0}};
        end
      end
      ST_WELCOME: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_cnt_r[i] != CNT_ZERO_C) begin
            ch_cnt_nxt_s[i] = ch_cnt_r[i] - CNT_ONE_C;
            ch_out_nxt_s[i] = (ch_cnt_r[i] == CNT_ONE_C) ? 1'b0 : ch_out_r[i];
          end else begin
            ch_cnt_nxt_s[i] = CNT_ZERO_C;
            ch_out_nxt_s[i] = 1'b0;
          end
        end
        if (all_done_s) begin
          state_nxt_s  = ST_WAIT_LEAVE;
          wcount_nxt_s = (wcount_r != COUNT_MAX_C) ? (wcount_r + COUNT_ONE_C) : wcount_r;
        end else begin
          state_nxt_s = ST_WELCOME;
        end
      end
      ST_WAIT_LEAVE: begin
        ch_out_nxt_s = {NUM_CH{1'b0}};
        if (!pres_f_r) begin
          state_nxt_s    = ST_COOLDOWN;
          cool_cnt_nxt_s = COOL_LOAD_C;
        end else begin
          state_nxt_s = ST_WAIT_LEAVE;
        end
      end
      ST_COOLDOWN: begin
        ch_out_nxt_s = {NUM_CH{1'b0}};
        if (cool_cnt_r == CNT_ZERO_C) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cool_cnt_nxt_s = cool_cnt_r - CNT_ONE_C;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        ch_out_nxt_s = {NUM_CH{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_r    <= ST_IDLE;
      ch_out_r   <= {NUM_CH{1'b0}};
      cool_cnt_r <= CNT_ZERO_C;
      wcount_r   <= {COUNT_W{1'b0}};
      busy_r     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_r[i] <= CNT_ZERO_C;
      end
    end else begin
      state_r    <= state_nxt_s;
      ch_out_r   <= ch_out_nxt_s;
      cool_cnt_r <= cool_cnt_nxt_s;
      wcount_r   <= wcount_nxt_s;
      busy_r     <= (state_nxt_s == ST_WELCOME);
      for (int i = 0; i < NUM_CH; i++) begin
        ch_cnt_r[i] <= ch_cnt_nxt_s[i];
      end
    end
  end

  assign bus.out_channels      = ch_out_r;
  assign bus.out_busy          = busy_r;
  assign bus.out_state         = state_r;
  assign bus.out_presence      = pres_f_r;
  assign bus.out_welcome_count = wcount_r;

endmodule

// File: tb/tb_welcomer_sequencer.sv
// Self-checking bench for welcomer_sequencer with short debounce/cooldown.
// Expected welcome records are queued when a visit is staged and compared
// when the sequencer produces the welcome.
module tb_welcomer_sequencer;
  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 32;
  localparam int DEB     = 4;
  localparam int COOL    = 8;
  localparam int COUNT_W = 4;

  logic in_clock = 1'b0;
  logic in_reset = 1'b1;
  logic in_presence_signal = 1'b0;

  always #5 in_clock = ~in_clock;

  welcomer_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .COUNT_W(COUNT_W)) bus ();

  welcomer_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEB),
    .COOLDOWN_CYCLES(COOL), .COUNT_W(COUNT_W)
  ) dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_presence_signal(in_presence_signal),
    .bus(bus)
  );

  typedef struct {
    int         len0;
    int         len1;
    int         wel_len;
    logic [1:0] first_ch;
    int         count;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_count = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stage a visit: drive enables/durations and queue the welcome it must produce.
  task automatic push_welcome(input int d0, input int d1, input logic [1:0] en);
    exp_t e;
    int   e0;
    int   e1;
    bus.in_durations      = {32'(d1), 32'(d0)};
    bus.in_channel_enable = en;
    e0 = en[0] ? d0 : 0;
    e1 = en[1] ? d1 : 0;
    exp_count  = (exp_count < 15) ? exp_count + 1 : 15;
    e.len0     = e0;
    e.len1     = e1;
    e.wel_len  = ((e0 > e1) ? e0 : e1) + 1;
    e.first_ch = {(e1 != 0), (e0 != 0)};
    e.count    = exp_count;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int budget, output int waited);
    waited = 0;
    while (bus.out_state !== s && waited < budget) begin
      @(negedge in_clock);
      waited++;
    end
    if (bus.out_state !== s) check_value({tag, "_timeout"}, 64'(bus.out_state), 64'(s));
  endtask

  // Called at a negedge in the first WELCOME cycle; drop_at<=0 keeps presence.
  task automatic capture_welcome(input string tag, input int drop_at);
    exp_t       e;
    int         l0 = 0;
    int         l1 = 0;
    int         len = 0;
    logic       busy_ok = 1'b1;
    logic [1:0] first;
    if (exp_q.size() == 0) begin
      check_value({tag, "_queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    first = bus.out_channels;
    bus.in_durations      = {$urandom(), $urandom()};
    bus.in_channel_enable = 2'($urandom());
    while (bus.out_state === 2'd1 && len < 100) begin
      if (bus.out_channels[0] === 1'b1) l0++;
      if (bus.out_channels[1] === 1'b1) l1++;
      if (bus.out_busy !== 1'b1) busy_ok = 1'b0;
      len++;
      if (len == drop_at) in_presence_signal = 1'b0;
      @(negedge in_clock);
    end
    check_value({tag, "_first_ch"}, 64'(first), 64'(e.first_ch));
    check_value({tag, "_ch0_len"}, 64'(l0), 64'(e.len0));
    check_value({tag, "_ch1_len"}, 64'(l1), 64'(e.len1));
    check_value({tag, "_welcome_len"}, 64'(len), 64'(e.wel_len));
    check_value({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check_value({tag, "_next_state"}, 64'(bus.out_state), 64'd2);
    check_value({tag, "_count"}, 64'(bus.out_welcome_count), 64'(e.count));
  endtask

  // Called at a negedge in the first COOLDOWN cycle; raise_at>0 brings the visitor back.
  task automatic measure_cooldown(input string tag, input int raise_at);
    int   len = 0;
    logic quiet = 1'b1;
    while (bus.out_state === 2'd3 && len < 50) begin
      if (bus.out_channels !== 2'b00 || bus.out_busy !== 1'b0) quiet = 1'b0;
      len++;
      if (len == raise_at) in_presence_signal = 1'b1;
      @(negedge in_clock);
    end
    check_value({tag, "_len"}, 64'(len), 64'(COOL + 1));
    check_value({tag, "_quiet"}, 64'(quiet), 64'd1);
    check_value({tag, "_idle"}, 64'(bus.out_state), 64'd0);
  endtask

  initial begin
    int   w;
    logic bad;
    bus.in_durations      = '0;
    bus.in_channel_enable = 2'b00;
    repeat (3) @(negedge in_clock);
    in_reset = 1'b0;

    check_value("rst_state", 64'(bus.out_state), 64'd0);
    check_value("rst_channels", 64'(bus.out_channels), 64'd0);
    check_value("rst_busy", 64'(bus.out_busy), 64'd0);
    check_value("rst_presence", 64'(bus.out_presence), 64'd0);
    check_value("rst_count", 64'(bus.out_welcome_count), 64'd0);

    // 3-cycle glitch must be rejected.
    in_presence_signal = 1'b1;
    repeat (3) @(negedge in_clock);
    in_presence_signal = 1'b0;
    bad = 1'b0;
    repeat (15) begin
      if (bus.out_state !== 2'd0 || bus.out_channels !== 2'b00 || bus.out_presence !== 1'b0) bad = 1'b1;
      @(negedge in_clock);
    end
    check_value("glitch_quiet", 64'(bad), 64'd0);

    // Basic welcome, latency from the raw edge.
    push_welcome(3, 6, 2'b11);
    in_presence_signal = 1'b1;
    wait_state("w1", 2'd1, 50, w);
    check_value("w1_latency", 64'(w), 64'd7);
    check_value("w1_presence", 64'(bus.out_presence), 64'd1);
    capture_welcome("w1", 0);
    in_presence_signal = 1'b0;
    wait_state("w1_leave", 2'd3, 50, w);
    measure_cooldown("cool1", 0);

    // Only channel 0 enabled, channel 1 zero duration.
    push_welcome(5, 0, 2'b01);
    in_presence_signal = 1'b1;
    wait_state("w2", 2'd1, 50, w);
    capture_welcome("w2", 0);
    in_presence_signal = 1'b0;
    wait_state("w2_leave", 2'd3, 50, w);
    wait_state("w2_idle", 2'd0, 50, w);

    // Nothing enabled: one-cycle welcome that still counts.
    push_welcome(4, 7, 2'b00);
    in_presence_signal = 1'b1;
    wait_state("w3", 2'd1, 50, w);
    capture_welcome("w3", 0);
    in_presence_signal = 1'b0;
    wait_state("w3_leave", 2'd3, 50, w);
    wait_state("w3_idle", 2'd0, 50, w);

    // Visitor leaves on the 2nd WELCOME cycle; welcome completes anyway.
    push_welcome(3, 6, 2'b11);
    in_presence_signal = 1'b1;
    wait_state("w4", 2'd1, 50, w);
    capture_welcome("w4", 2);
    wait_state("w4_leave", 2'd3, 50, w);

    // Visitor returns during cooldown and stays.
    push_welcome(6, 2, 2'b11);
    measure_cooldown("cool2", 1);
    wait_state("w5", 2'd1, 50, w);
    check_value("w5_idle_gap", 64'(w), 64'd1);
    capture_welcome("w5", 0);

    // Twelve more welcomes: count must saturate at 15 after 17 total.
    for (int k = 0; k < 12; k++) begin
      in_presence_signal = 1'b0;
      wait_state("sat_leave", 2'd3, 50, w);
      push_welcome(2, 1, 2'b11);
      in_presence_signal = 1'b1;
      wait_state("sat", 2'd1, 60, w);
      capture_welcome("sat", 0);
    end
    check_value("sat_final", 64'(bus.out_welcome_count), 64'd15);

    // Reset on the 2nd WELCOME cycle.
    in_presence_signal = 1'b0;
    wait_state("r_leave", 2'd3, 50, w);
    wait_state("r_idle", 2'd0, 50, w);
    bus.in_durations      = {32'd6, 32'd3};
    bus.in_channel_enable = 2'b11;
    in_presence_signal    = 1'b1;
    wait_state("r_wel", 2'd1, 50, w);
    @(negedge in_clock);
    in_reset = 1'b1;
    @(posedge in_clock);
    #1;
    check_value("mid_rst_state", 64'(bus.out_state), 64'd0);
    check_value("mid_rst_channels", 64'(bus.out_channels), 64'd0);
    check_value("mid_rst_busy", 64'(bus.out_busy), 64'd0);
    check_value("mid_rst_presence", 64'(bus.out_presence), 64'd0);
    check_value("mid_rst_count", 64'(bus.out_welcome_count), 64'd0);
    in_reset           = 1'b0;
    in_presence_signal = 1'b0;
    repeat (3) @(negedge in_clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
